// File: rtl/muxn_rr_reg_if.sv
// Channel-side and output-side handshake bundle for muxn_rr_reg.
// The slave side is the mux itself; the master side is whatever feeds it and drains it.
interface muxn_rr_reg_if #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned n_inputs  = 5,
  parameter int unsigned sel_w     = 3
);
  logic [n_inputs*bit_width-1:0] in_data;
  logic [n_inputs-1:0]           in_valid;
  logic [n_inputs-1:0]           in_ready;
  logic [bit_width-1:0]          y;
  logic                          y_valid;
  logic                          y_ready;
  logic [sel_w-1:0]              y_src;

  modport master (
    output in_data, in_valid, y_ready,
    input  in_ready, y, y_valid, y_src
  );

  modport slave (
    input  in_data, in_valid, y_ready,
    output in_ready, y, y_valid, y_src
  );
endinterface

// File: rtl/muxn_rr_reg.sv
// N-way registered multiplexer: direct select (mode=0) or round-robin arbitration (mode=1)
// into a single output register with valid/ready flow control.
module muxn_rr_reg #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned n_inputs  = 5,
  parameter int unsigned sel_w     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [sel_w-1:0] s,
  muxn_rr_reg_if.slave     bus,
  output logic             sel_err
);

  logic [bit_width-1:0] y_q;
  logic                 y_valid_q;
  logic [sel_w-1:0]     y_src_q;
  logic [sel_w-1:0]     rr_ptr;

  logic                 load_en;
  logic                 s_in_range;
  logic                 gnt_vld;
  logic [sel_w-1:0]     gnt_idx;
  logic [bit_width-1:0] gnt_data;
  logic [n_inputs-1:0]  in_ready_c;

  assign load_en    = !y_valid_q || bus.y_ready;
  assign s_in_range = 32'(s) < n_inputs;

  // Round-robin search done as two passes over constant indices: first the
  // lowest valid channel at or above rr_ptr, then (wrap) the lowest overall.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < n_inputs; i++) begin
        if (s == sel_w'(i) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = sel_w'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < n_inputs; i++) begin
        if (!gnt_vld && bus.in_valid[i] && 32'(rr_ptr) <= i) begin
          gnt_vld = 1'b1;
          gnt_idx = sel_w'(i);
        end
      end
      for (int unsigned i = 0; i < n_inputs; i++) begin
        if (!gnt_vld && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = sel_w'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data   = '0;
    in_ready_c = '0;
    for (int unsigned i = 0; i < n_inputs; i++) begin
      if (gnt_idx == sel_w'(i)) begin
        gnt_data      = bus.in_data[i*bit_width +: bit_width];
        in_ready_c[i] = load_en && gnt_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= '0;
      rr_ptr    <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= !mode && load_en && !s_in_range;
      if (load_en) begin
        if (gnt_vld) begin
          y_q       <= gnt_data;
          y_src_q   <= gnt_idx;
          y_valid_q <= 1'b1;
          if (mode) begin
            if (32'(gnt_idx) == n_inputs - 1) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= gnt_idx + 1'b1;
            end
          end
        end else begin
          y_valid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = rst_n ? in_ready_c : '0;
    bus.y        = y_q;
    bus.y_valid  = y_valid_q;
    bus.y_src    = y_src_q;
  end

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Self-checking bench for muxn_rr_reg: a rule-level reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_muxn_rr_reg;
  localparam int N  = 5;
  localparam int BW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [SW-1:0] s;
  logic          sel_err;
  logic [BW-1:0] ch [N];

  muxn_rr_reg_if #(.bit_width(BW), .n_inputs(N), .sel_w(SW)) bus ();

  muxn_rr_reg #(.bit_width(BW), .n_inputs(N), .sel_w(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .s       (s),
    .bus     (bus.slave),
    .sel_err (sel_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) bus.in_data[i*BW +: BW] = ch[i];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: output register contents and the round-robin pointer.
  logic [BW-1:0] m_y     = '0;
  logic          m_valid = 1'b0;
  logic          m_err   = 1'b0;
  int            m_src   = 0;
  int            m_ptr   = 0;

  function automatic int grant_of();
    logic [31:0] v;
    v = 32'(bus.in_valid);
    if (!mode) begin
      for (int c = 0; c < N; c++)
        if (int'(s) == c && ((v >> c) & 32'd1) != 0) return c;
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (((v >> c) & 32'd1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = grant_of();
    if (rst_n === 1'b1 && (!m_valid || bus.y_ready) && g >= 0) return N'(32'd1 << g);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = '0; m_valid = 1'b0; m_err = 1'b0; m_src = 0; m_ptr = 0;
    end else begin
      bit le;
      int g;
      le = !m_valid || bus.y_ready;
      g  = grant_of();
      m_err = !mode && le && int'(s) >= N;
      if (le) begin
        if (g >= 0) begin
          m_y = ch[g]; m_src = g; m_valid = 1'b1;
          if (mode) m_ptr = (g + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_y",        32'(bus.y),        32'(m_y));
    chk("model_y_valid",  32'(bus.y_valid),  32'(m_valid));
    chk("model_y_src",    32'(bus.y_src),    32'(m_src));
    chk("model_sel_err",  32'(sel_err),      32'(m_err));
    chk("model_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_exp [7] = '{0, 1, 2, 3, 4, 0, 1};

  initial begin
    rst_n = 1'b0; mode = 1'b0; s = '0;
    bus.in_valid = '0; bus.y_ready = 1'b0;
    for (int i = 0; i < N; i++) ch[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_y",        32'(bus.y),        32'h0);
    chk("rst_y_valid",  32'(bus.y_valid),  32'h0);
    chk("rst_y_src",    32'(bus.y_src),    32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_sel_err",  32'(sel_err),      32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Round-robin over five valid channels straight after reset
    mode = 1'b1; bus.in_valid = 5'b11111; bus.y_ready = 1'b1;
    for (int i = 0; i < N; i++) ch[i] = 16'(16'h1000 + i);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("rr_seq_src", 32'(bus.y_src), 32'(rr_exp[k]));
      chk("rr_seq_y",   32'(bus.y),     32'(16'h1000 + rr_exp[k]));
    end

    // Direct select of channel 3
    mode = 1'b0; s = 3'd3; bus.in_valid = 5'b01000; ch[3] = 16'hBEEF;
    #1 chk("dir_in_ready", 32'(bus.in_ready), 32'h08);
    step();
    chk("dir_y",       32'(bus.y),       32'hBEEF);
    chk("dir_y_valid", 32'(bus.y_valid), 32'h1);
    chk("dir_y_src",   32'(bus.y_src),   32'h3);

    // Out-of-range select
    s = 3'd6; bus.in_valid = 5'b11111;
    #1 chk("oor_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    chk("oor_sel_err", 32'(sel_err),     32'h1);
    chk("oor_y_valid", 32'(bus.y_valid), 32'h0);
    chk("oor_y_hold",  32'(bus.y),       32'hBEEF);
    s = 3'd0; bus.in_valid = '0;
    step();
    chk("oor_err_once", 32'(sel_err), 32'h0);

    // Back-pressure in round-robin: rr_ptr is 2 after the sequence above
    mode = 1'b1; bus.in_valid = 5'b01010; ch[1] = 16'h1111; ch[3] = 16'h3333;
    step();
    chk("bp_first_src", 32'(bus.y_src), 32'h3);
    chk("bp_first_y",   32'(bus.y),     32'h3333);
    bus.y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("bp_hold_y",     32'(bus.y),       32'h3333);
      chk("bp_hold_src",   32'(bus.y_src),   32'h3);
      chk("bp_hold_valid", 32'(bus.y_valid), 32'h1);
    end
    bus.y_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'h02);
    step();
    chk("bp_next_src",   32'(bus.y_src),   32'h1);
    chk("bp_next_y",     32'(bus.y),       32'h1111);
    chk("bp_next_valid", 32'(bus.y_valid), 32'h1);

    // Mixed modes, selects, valids and back-pressure; checked by the model
    for (int i = 0; i < 48; i++) begin
      mode         = ((i / 6) % 2) != 0;
      s            = SW'(i % 7);
      bus.in_valid = N'((i * 13 + 5) % 32);
      bus.y_ready  = (i % 4) != 1;
      for (int c = 0; c < N; c++) ch[c] = 16'(i * 256 + c);
      step();
    end

    // Reset while holding a word from channel 2
    mode = 1'b0; s = 3'd2; bus.in_valid = 5'b11111; bus.y_ready = 1'b1; ch[2] = 16'h2222;
    step();
    chk("rst_pre_src",   32'(bus.y_src),   32'h2);
    chk("rst_pre_valid", 32'(bus.y_valid), 32'h1);
    bus.y_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.y_valid), 32'h0);
    chk("async_rst_y",     32'(bus.y),       32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1; mode = 1'b1; bus.in_valid = 5'b11111; bus.y_ready = 1'b1;
    step();
    chk("post_rst_src",   32'(bus.y_src),   32'h0);
    chk("post_rst_valid", 32'(bus.y_valid), 32'h1);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
